// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
//   state_t       : controller states (IDLE, RUN, DONE)
//   DEFAULT_WIDTH : default operand/result width in bits
package serial_add_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell.
//   A, B : operand bits
//   Ci   : carry in
//   S    : sum bit
//   Co   : carry out
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Ci,
  output logic S,
  output logic Co
);

  assign S  = A ^ B ^ Ci;
  assign Co = (A & B) | (Ci & (A ^ B));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell processes one
// operand bit per cycle, LSB first, and the finished word is presented on S.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   start      : request a new operation (accepted only in IDLE)
//   A, B, sub  : operands and mode (0 = A+B, 1 = A-B), captured on accept
//   busy       : operation in progress (RUN or DONE)
//   done       : one-cycle pulse when S/Co/OV are updated
//   S, Co, OV  : result, carry out (1 = no borrow for sub), signed overflow
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic             OV
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] op_a, op_b, result;
  logic [WIDTH-1:0] result_nxt;
  logic [CW-1:0]    count;
  logic             carry, cmsb;
  logic             fa_s, fa_co;
  logic             last_bit, pre_msb;

  full_adder u_fa (
    .A  (op_a[0]),
    .B  (op_b[0]),
    .Ci (carry),
    .S  (fa_s),
    .Co (fa_co)
  );

  assign last_bit   = (count == CW'(WIDTH - 1));
  assign pre_msb    = (count == CW'(WIDTH - 2));
  // New sum bit enters at the MSB; the oldest bit falls off the bottom.
  assign result_nxt = WIDTH'({fa_s, result} >> 1);

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
      carry  <= 1'b0;
      cmsb   <= 1'b0;
      count  <= '0;
      S      <= '0;
      Co     <= 1'b0;
      OV     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      done <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry.
            op_a  <= A;
            op_b  <= sub ? ~B : B;
            carry <= sub;
            count <= '0;
          end
        end
        RUN: begin
          op_a   <= op_a >> 1;
          op_b   <= op_b >> 1;
          result <= result_nxt;
          carry  <= fa_co;
          count  <= count + CW'(1);
          // Carry leaving bit WIDTH-2 is the carry into the MSB.
          if (pre_msb) cmsb <= fa_co;
          // Publish on the final bit so S/Co/OV are valid during DONE.
          if (last_bit) begin
            S  <= result_nxt;
            Co <= fa_co;
            OV <= ((WIDTH > 1) ? cmsb : carry) ^ fa_co;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start8, sub8, busy8, done8, co8, ov8;
  logic [7:0]  a8, b8, s8;
  logic        start16, sub16, busy16, done16, co16, ov16;
  logic [15:0] a16, b16, s16;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .A(a8), .B(b8), .sub(sub8),
    .busy(busy8), .done(done8), .S(s8), .Co(co8), .OV(ov8)
  );

  serial_add_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .A(a16), .B(b16), .sub(sub16),
    .busy(busy16), .done(done16), .S(s16), .Co(co16), .OV(ov16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_s(input bit w16);
    return w16 ? 32'(s16) : 32'(s8);
  endfunction

  function automatic logic obs_done(input bit w16);
    return w16 ? done16 : done8;
  endfunction

  // Reference: returns {ov, co, sum}
  function automatic logic [33:0] model(input int unsigned w, input logic [31:0] a_i,
                                        input logic [31:0] b_i, input logic s);
    logic [63:0] mask, a, b, t, sum;
    logic        co, ov, am, bm, sm;
    mask = (64'(1) << w) - 64'(1);
    a = 64'(a_i) & mask;
    b = 64'(b_i) & mask;
    if (s) begin
      t  = (a - b) & mask;
      co = (a >= b);
    end else begin
      t  = a + b;
      co = t[w];
    end
    sum = t & mask;
    am = a[w-1];
    bm = b[w-1];
    sm = sum[w-1];
    ov = s ? ((am != bm) && (sm != am)) : ((am == bm) && (sm != am));
    return {ov, co, sum[31:0]};
  endfunction

  // Issue one operation, wait for done, check latency, S stability and results.
  task automatic run_op(input bit w16, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [31:0] exp_s, input logic exp_co,
                        input logic exp_ov, input string tag);
    logic [31:0] hold;
    int          cyc;
    bit          seen, stable;
    @(negedge clk);
    if (w16) begin a16 = a[15:0]; b16 = b[15:0]; sub16 = s; start16 = 1'b1; end
    else     begin a8  = a[7:0];  b8  = b[7:0];  sub8  = s; start8  = 1'b1; end
    hold = obs_s(w16);
    @(posedge clk);
    @(negedge clk);
    start8  = 1'b0;
    start16 = 1'b0;
    cyc    = 1;
    stable = 1'b1;
    seen   = obs_done(w16);
    while (!seen && cyc < 60) begin
      if (obs_s(w16) !== hold) stable = 1'b0;
      @(negedge clk);
      cyc++;
      seen = obs_done(w16);
    end
    check({tag, " latency"}, 32'(cyc), w16 ? 32'd17 : 32'd9);
    check({tag, " S stable in RUN"}, 32'(stable), 32'd1);
    check({tag, " S"}, obs_s(w16), exp_s);
    check({tag, " Co/OV"}, w16 ? {30'd0, co16, ov16} : {30'd0, co8, ov8},
          {30'd0, exp_co, exp_ov});
    @(negedge clk);
    check({tag, " done/busy after"}, w16 ? {30'd0, done16, busy16} : {30'd0, done8, busy8}, 32'd0);
  endtask

  initial begin
    logic [33:0] m;
    logic [31:0] ra, rb;
    logic        rs;
    int          pulses, first_done, second_done, cyc;
    logic [7:0]  s_at_done;

    reset = 1'b1;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0;
    repeat (2) @(negedge clk);
    check("reset outputs w8", {21'd0, busy8, done8, co8, ov8, s8}, 32'd0);
    check("reset outputs w16", {13'd0, busy16, done16, co16, ov16, s16}, 32'd0);
    reset = 1'b0;

    // Directed arithmetic cases
    run_op(1'b0, 32'h7F, 32'h01, 1'b0, 32'h80, 1'b0, 1'b1, "7F+01");
    run_op(1'b0, 32'hFF, 32'h01, 1'b0, 32'h00, 1'b1, 1'b0, "FF+01");
    run_op(1'b0, 32'h05, 32'h07, 1'b1, 32'hFE, 1'b0, 1'b0, "05-07");
    run_op(1'b0, 32'h80, 32'h01, 1'b1, 32'h7F, 1'b1, 1'b1, "80-01");
    run_op(1'b0, 32'h00, 32'h00, 1'b1, 32'h00, 1'b1, 1'b0, "00-00");
    run_op(1'b1, 32'h7FFF, 32'h0001, 1'b0, 32'h8000, 1'b0, 1'b1, "w16 7FFF+1");
    run_op(1'b1, 32'h1234, 32'h1235, 1'b1, 32'hFFFF, 1'b0, 1'b0, "w16 1234-1235");

    // Start during RUN is ignored; exactly one done
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    pulses = 0;
    s_at_done = 8'h00;
    for (int i = 2; i < 30; i++) begin
      if (i == 3) begin a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1; end
      else start8 = 1'b0;
      @(negedge clk);
      if (done8) begin pulses++; s_at_done = s8; end
    end
    check("ignored start pulses", 32'(pulses), 32'd1);
    check("ignored start S", 32'(s_at_done), 32'h30);

    // Reset during RUN aborts with no done
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h22; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid-run reset outputs", {21'd0, busy8, done8, co8, ov8, s8}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 1) reset = 1'b0;
      if (done8) pulses++;
    end
    check("no done after abort", 32'(pulses), 32'd0);
    run_op(1'b0, 32'h12, 32'h34, 1'b0, 32'h46, 1'b0, 1'b0, "after reset 12+34");

    // start held high: back-to-back operations, done pulses WIDTH+2 apart
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h02; sub8 = 1'b0; start8 = 1'b1;
    first_done = -1; second_done = -1;
    cyc = 0;
    while (second_done < 0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (done8) begin
        if (first_done < 0) first_done = cyc;
        else second_done = cyc;
      end
    end
    start8 = 1'b0;
    check("held start gap", 32'(second_done - first_done), 32'd10);
    check("held start S", 32'(s8), 32'h03);
    repeat (12) @(negedge clk);

    // Random sweep over both widths and both modes
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      m  = model((i % 2 == 1) ? 16 : 8, ra, rb, rs);
      run_op(i % 2 == 1, ra, rb, rs, m[31:0], m[32], m[33], "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a new operation; sampled on each rising clk edge.
REQ-005 A  input  WIDTH  first operand; sampled only on an accepted start.
REQ-006 B  input  WIDTH  second operand; sampled only on an accepted start.
REQ-007 sub  input  1  0 = A+B, 1 = A-B; sampled only on an accepted start.
REQ-008 busy  output  1  high while an operation is in progress (RUN or DONE).
REQ-009 done  output  1  one-cycle pulse when S/Co/OV become valid.
REQ-010 S  output  WIDTH  registered result.
REQ-011 Co  output  1  carry out of the MSB; for sub, 1 = no borrow.
REQ-012 OV  output  1  two's-complement signed overflow.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 IDLE: start=1 SHALL be accepted, loading opA<=A, opB<=(sub ? ~B : B), carry<=sub, count<=0 and moving to RUN.
REQ-015 start SHALL be ignored in RUN and DONE; operands in flight are unaffected.
REQ-016 RUN, each cycle: one FA cell SHALL add opA[0], opB[0] and carry; the sum bit SHALL shift into the MSB of an internal result register; carry<=FA carry-out; opA and opB SHALL shift right by 1; count SHALL increment.
REQ-017 In RUN, on the cycle count==WIDTH-2 the carry-in is saved as cmsb (carry into MSB) before the final bit.
REQ-018 RUN SHALL move to DONE after exactly WIDTH bit-cycles (count==WIDTH-1 processed).
REQ-019 DONE SHALL last one cycle: S<=result register, Co<=carry, OV<=cmsb^carry, done=1; then return to IDLE.
REQ-020 Latency: start accepted at edge 0 -> done high in the cycle after edge WIDTH; S/Co/OV valid from that same cycle.
REQ-021 S, Co and OV SHALL hold their last values until the next DONE; they SHALL NOT change during RUN.
REQ-022 busy SHALL be 1 in RUN and DONE, 0 in IDLE; done SHALL be 1 only in DONE.
REQ-023 Arithmetic is modulo 2^WIDTH; count width SHALL be $clog2(WIDTH).
REQ-024 start held high continuously SHALL start a new operation on the first IDLE cycle after each DONE.

Reset
REQ-025 reset=1 SHALL asynchronously force state=IDLE, and opA, opB, result, carry, cmsb, count, S, Co, OV, busy and done all to 0.
REQ-026 reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after reset release SHALL complete correctly.

Structure
REQ-027 Package serial_add_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the constant DEFAULT_WIDTH=8.
REQ-028 The bit adder SHALL be one instance of the team's existing full-adder module (inputs A, B, Ci; outputs S, Co); no other sub-modules.

Verification
REQ-029 WIDTH=8, A=0x7F, B=0x01, sub=0 -> done 9 cycles after start edge; S=0x80, Co=0, OV=1.
REQ-030 A=0xFF, B=0x01, sub=0 -> S=0x00, Co=1, OV=0.
REQ-031 A=0x05, B=0x07, sub=1 -> S=0xFE, Co=0 (borrow), OV=0; A=0x80, B=0x01, sub=1 -> S=0x7F, Co=1, OV=1.
REQ-032 Start 0x10+0x20, pulse start with 0xFF+0xFF at RUN cycle 3 -> second start ignored; S=0x30, exactly one done pulse.
REQ-033 reset asserted during RUN cycle 4 -> all outputs 0 immediately, no done; then 0x12+0x34 -> S=0x46, Co=0, OV=0.
REQ-034 Random sweep of 1000 operand pairs, both modes, WIDTH=8 and WIDTH=16 -> S, Co and OV match a reference model; S stable throughout each RUN.
